// File: rtl/sonata_clkgen_pkg.sv
`timescale 1ns / 1ps
// sonata_clkgen_pkg: shared clock constants and default parameters for the
// Sonata clock/reset generator.
//   BoardClkHz / SysClkHz  nominal board and system clock frequencies
//   Def*                    default parameter values used by sonata_clkgen
package sonata_clkgen_pkg;

    localparam int unsigned BoardClkHz       = 25_000_000;
    localparam int unsigned SysClkHz         = 50_000_000;

    localparam int unsigned DefClkMult       = SysClkHz / BoardClkHz;
    localparam int unsigned DefLockCycles    = 64;
    localparam int unsigned DefRstSyncStages = 2;
    localparam int unsigned DefRstHoldCycles = 16;

endpackage

// File: rtl/sonata_pll.sv
`timescale 1ns / 1ps
// sonata_pll: behavioural PLL model. The FPGA build replaces this file with a
// wrapper of the same name around the vendor MMCM/PLL and BUFG.
// Ports:
//   clk_in   in   reference clock
//   rst      in   active-high PLL reset, sampled on clk_in
//   clk_out  out  clk_in x ClkMult, rising edges aligned to clk_in rising edges
//   locked   out  high LockCycles clk_in cycles after rst is released
module sonata_pll
    import sonata_clkgen_pkg::*;
#(
    parameter int unsigned ClkMult    = DefClkMult,
    parameter int unsigned LockCycles = DefLockCycles
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out,
    output logic locked
);

    localparam int unsigned LockW = $clog2(LockCycles + 1);
    localparam logic [LockW-1:0] LockMax = LockW'(LockCycles);

    logic [LockW-1:0] r_lock_cnt = '0;
    logic             r_locked   = 1'b0;
    logic [LockW-1:0] w_lock_cnt_inc;

    assign w_lock_cnt_inc = r_lock_cnt + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (r_lock_cnt != LockMax) begin
            r_lock_cnt <= w_lock_cnt_inc;
            r_locked   <= (w_lock_cnt_inc == LockMax);
        end
    end

    // Oscillator: the reference half-period is measured edge to edge and
    // split into ClkMult output toggles. Output rises on every clk_in rise.
    real  r_last_edge = -1.0;
    real  r_step      = 0.0;
    logic r_clk_out   = 1'b0;

    always begin
        @(clk_in);
        if (r_last_edge >= 0.0) begin
            r_step = ($realtime - r_last_edge) / ClkMult;
        end
        r_last_edge = $realtime;
        if (r_step > 0.0) begin
            for (int unsigned i = 0; i < ClkMult; i++) begin
                if (i != 0) begin
                    #(r_step);
                end
                if (i == 0 && clk_in) begin
                    r_clk_out = 1'b1;
                end else begin
                    r_clk_out = ~r_clk_out;
                end
            end
        end
    end

    assign clk_out = r_clk_out;
    assign locked  = r_locked;

endmodule

// File: rtl/sonata_clkgen.sv
`timescale 1ns / 1ps
// sonata_clkgen: Sonata top-level clock and reset generation.
// Ports:
//   IO_CLK      in   25 MHz board oscillator
//   IO_RST      in   synchronous active-high reset, sampled on IO_CLK_BUF
//   IO_CLK_BUF  out  buffered IO_CLK for board-domain logic
//   clk_sys     out  IO_CLK x ClkMult, held low while the PLL is unlocked
//   rst_sys_n   out  active-low reset, synchronous to clk_sys
module sonata_clkgen
    import sonata_clkgen_pkg::*;
#(
    parameter int unsigned ClkMult       = DefClkMult,
    parameter int unsigned LockCycles    = DefLockCycles,
    parameter int unsigned RstSyncStages = DefRstSyncStages,
    parameter int unsigned RstHoldCycles = DefRstHoldCycles
) (
    input  logic IO_CLK,
    input  logic IO_RST,
    output logic IO_CLK_BUF,
    output logic clk_sys,
    output logic rst_sys_n
);

    localparam int unsigned CntW = $clog2(RstHoldCycles + 1);
    localparam logic [CntW-1:0] HoldMax = CntW'(RstHoldCycles);

    assign IO_CLK_BUF = IO_CLK;

    // PLL held in reset from power-up until the first IO_CLK_BUF edge.
    logic r_pll_rst = 1'b1;

    always_ff @(posedge IO_CLK_BUF) begin
        r_pll_rst <= IO_RST;
    end

    logic w_pll_clk;
    logic w_locked;

    sonata_pll #(
        .ClkMult    (ClkMult),
        .LockCycles (LockCycles)
    ) u_pll (
        .clk_in  (IO_CLK_BUF),
        .rst     (r_pll_rst),
        .clk_out (w_pll_clk),
        .locked  (w_locked)
    );

    // Enable only changes while the PLL clock is low, so the AND gate can
    // never chop a high phase short.
    logic r_gate_en = 1'b0;

    always_ff @(negedge w_pll_clk) begin
        r_gate_en <= w_locked;
    end

    assign clk_sys = w_pll_clk & r_gate_en;

    logic w_rst_req;
    assign w_rst_req = r_pll_rst | ~w_locked;

    // Asynchronous assert, synchronous release into clk_sys.
    logic [RstSyncStages-1:0] r_sync = '0;
    logic                     w_sync_out;

    always_ff @(posedge clk_sys or posedge w_rst_req) begin
        if (w_rst_req) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | RstSyncStages'(1);
        end
    end

    assign w_sync_out = r_sync[RstSyncStages-1];

    logic [CntW-1:0] r_cnt   = '0;
    logic            r_rst_n = 1'b0;
    logic [CntW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_sync_out) begin
            w_cnt_next = '0;
        end else if (r_cnt != HoldMax) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Gating on w_sync_out drops the reset on the first clk_sys edge after a
    // request instead of one edge later when the stale count is still full.
    always_ff @(posedge clk_sys) begin
        r_cnt   <= w_cnt_next;
        r_rst_n <= w_sync_out && (r_cnt == HoldMax);
    end

    assign rst_sys_n = r_rst_n;

endmodule

// File: tb/tb_sonata_clkgen.sv
`timescale 1ns / 1ps
module tb_sonata_clkgen;

    logic IO_CLK = 1'b0;
    logic IO_RST = 1'b0;
    logic IO_CLK_BUF;
    logic clk_sys;
    logic rst_sys_n;
    logic io_clk_buf_2;
    logic clk_sys_2;
    logic rst_sys_n_2;

    int checks = 0;
    int errors = 0;

    always #20 IO_CLK = ~IO_CLK;

    sonata_clkgen dut (
        .IO_CLK     (IO_CLK),
        .IO_RST     (IO_RST),
        .IO_CLK_BUF (IO_CLK_BUF),
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n)
    );

    sonata_clkgen #(
        .RstHoldCycles (1),
        .RstSyncStages (3)
    ) dut2 (
        .IO_CLK     (IO_CLK),
        .IO_RST     (IO_RST),
        .IO_CLK_BUF (io_clk_buf_2),
        .clk_sys    (clk_sys_2),
        .rst_sys_n  (rst_sys_n_2)
    );

    // Monitors
    int  sys_edges      = 0;
    bit  arm            = 1'b1;
    real armed_rise_t   = -1.0;
    real last_rise_t    = 0.0;
    real prev_rise_t    = 0.0;
    int  runts          = 0;
    int  rst_rises      = 0;
    int  rst_falls      = 0;
    real rst_rise_t     = -1.0;
    int  rst_rise_edges = -1;
    real buf_last       = 0.0;
    real buf_prev       = 0.0;
    real clk_last       = 0.0;
    int  edges2         = 0;
    bit  rst2_seen      = 1'b0;
    int  rst2_edges     = -1;
    real rst2_t         = -1.0;

    always @(posedge clk_sys) begin
        sys_edges++;
        prev_rise_t = last_rise_t;
        last_rise_t = $realtime;
        if (arm) begin
            arm = 1'b0;
            armed_rise_t = $realtime;
        end
    end

    always @(negedge clk_sys) begin
        if ($realtime - last_rise_t < 9.9) runts++;
    end

    always @(posedge rst_sys_n) begin
        rst_rises++;
        rst_rise_t = $realtime;
        rst_rise_edges = sys_edges;
    end

    always @(negedge rst_sys_n) rst_falls++;

    always @(posedge IO_CLK_BUF) begin
        buf_prev = buf_last;
        buf_last = $realtime;
    end

    always @(posedge IO_CLK) clk_last = $realtime;

    always @(posedge clk_sys_2) edges2++;

    always @(posedge rst_sys_n_2) begin
        if (!rst2_seen) begin
            rst2_seen = 1'b1;
            rst2_edges = edges2;
            rst2_t = $realtime;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rst_rise(input int r0, input int budget_ns);
        for (int i = 0; i < budget_ns && rst_rises == r0; i++) #1;
    endtask

    int  base;
    int  r0;
    int  f0;
    int  s0;
    real release_t;

    initial begin
        // Power-up: first IO_CLK_BUF edge at 20 ns, lock at 2580 ns,
        // first clk_sys rise 2600 ns, rst_sys_n on edge 19 at 2960 ns.
        base = 0;
        #5;
        check("reset_rst_sys_n", int'(rst_sys_n), 0);
        check("reset_clk_sys", int'(clk_sys), 0);
        check("buf_copy", int'(io_clk_buf_2), int'(IO_CLK));

        wait_rst_rise(0, 5000);
        check("pwr_rst_rises", rst_rises, 1);
        check("pwr_first_sys_rise_ns", int'(armed_rise_t), 2600);
        check("pwr_deassert_edges", rst_rise_edges - base, 19);
        check("pwr_deassert_ns", int'(rst_rise_t), 2960);
        check("sweep_deassert_edges", rst2_edges, 5);
        check("sweep_deassert_ns", int'(rst2_t), 2680);

        #100;
        check("sys_period_x10", int'((last_rise_t - prev_rise_t) * 10.0), 200);
        check("buf_period_ns", int'(buf_last - buf_prev), 40);
        check("buf_phase_ps", int'((buf_last - clk_last) * 1000.0), 0);

        // Pulse entirely between IO_CLK edges is never sampled.
        f0 = rst_falls;
        @(posedge IO_CLK);
        #5 IO_RST = 1'b1;
        #10 IO_RST = 1'b0;
        #300;
        check("short_pulse_falls", rst_falls - f0, 0);
        check("short_pulse_rst_n", int'(rst_sys_n), 1);

        // IO_RST high for 10 IO_CLK edges.
        @(posedge IO_CLK);
        #5 IO_RST = 1'b1;
        @(posedge IO_CLK);
        @(posedge IO_CLK);
        #1;
        check("rst_low_next_edge", int'(rst_sys_n), 0);
        #20;
        s0 = sys_edges;
        repeat (8) @(posedge IO_CLK);
        #5;
        check("clk_sys_stopped", sys_edges - s0, 0);
        IO_RST = 1'b0;
        release_t = $realtime;
        r0 = rst_rises;
        base = sys_edges;
        arm = 1'b1;
        wait_rst_rise(r0, 4000);
        check("relock_rst_rises", rst_rises - r0, 1);
        check("relock_first_rise_ns", int'(armed_rise_t), int'(release_t) + 2615);
        check("relock_deassert_edges", rst_rise_edges - base, 19);
        check("relock_deassert_ns", int'(rst_rise_t), int'(release_t) + 2975);
        check("relock_runts", runts, 0);

        // Reset arriving mid hold count restarts the whole sequence.
        @(posedge IO_CLK);
        #5 IO_RST = 1'b1;
        @(posedge IO_CLK);
        #5 IO_RST = 1'b0;
        #50;
        base = sys_edges;
        arm = 1'b1;
        for (int i = 0; i < 4000 && (sys_edges - base) < 10; i++) #1;
        check("hold_reached_count8", int'((sys_edges - base) >= 10), 1);
        @(negedge IO_CLK);
        IO_RST = 1'b1;
        @(posedge IO_CLK);
        #5 IO_RST = 1'b0;
        release_t = $realtime;
        check("hold_rst_n_low", int'(rst_sys_n), 0);
        r0 = rst_rises;
        #50;
        base = sys_edges;
        arm = 1'b1;
        #2900;
        check("hold_no_early_rise", rst_rises - r0, 0);
        wait_rst_rise(r0, 1000);
        check("hold_rst_rises", rst_rises - r0, 1);
        check("hold_first_rise_ns", int'(armed_rise_t), int'(release_t) + 2615);
        check("hold_deassert_edges", rst_rise_edges - base, 19);
        check("hold_deassert_ns", int'(rst_rise_t), int'(release_t) + 2975);

        // Steady state.
        f0 = rst_falls;
        #2000;
        check("steady_falls", rst_falls - f0, 0);
        check("steady_rst_n", int'(rst_sys_n), 1);
        check("steady_runts", runts, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sonata_clkgen.md
Name: sonata_clkgen

Overview:
Clock and reset generator for the Sonata FPGA top level.
- Buffers the 25 MHz board clock and returns the buffered copy for board-domain logic such as the power-on reset counter.
- Derives the 50 MHz system clock through a PLL sub-module.
- Produces an active-low system reset that is synchronous to clk_sys. It deasserts only after the PLL is locked and the input reset has been released.

Parameters:
- ClkMult, 2: clk_sys frequency = IO_CLK frequency × ClkMult (25 MHz → 50 MHz).
- LockCycles, 64: IO_CLK cycles from PLL reset release until locked asserts. Applies to the behavioural PLL model only.
- RstSyncStages, 2: flop stages of the reset synchroniser in the clk_sys domain.
- RstHoldCycles, 16: clk_sys cycles that rst_sys_n stays low after lock and reset release.

Ports:
- IO_CLK  input  1  board oscillator clock, 25 MHz; the single input clock.
- IO_RST  input  1  reset, synchronous and active-high; sampled on IO_CLK_BUF.
- IO_CLK_BUF  output  1  globally buffered copy of IO_CLK, same phase and frequency.
- clk_sys  output  1  system clock, IO_CLK × ClkMult; forced low while the PLL is unlocked.
- rst_sys_n  output  1  system reset, active-low, synchronous to clk_sys.

Behaviour:
- IO_CLK_BUF: combinational buffer of IO_CLK. No gating; toggles from time zero.
- PLL reset: pll_rst is registered on IO_CLK_BUF as pll_rst <= IO_RST, and is 1 at power-up (initial value).
- PLL lock:
  - locked goes low within one IO_CLK cycle of pll_rst being 1.
  - locked rises LockCycles IO_CLK cycles after pll_rst falls.
- clk_sys is gated by locked through a glitch-free gate, so no runt pulses occur.
- Reset request: rst_req = pll_rst | ~locked.
- Reset synchroniser (clk_sys domain):
  - Chain of RstSyncStages flops, asynchronously cleared by rst_req and shifting in 1; the assertion-asynchronous exception is local to this chain.
  - Its output feeds a hold counter of width clog2(RstHoldCycles+1).
  - Counter clears to 0 while the synchroniser output is 0.
  - Otherwise the counter increments, saturating at RstHoldCycles.
- rst_sys_n = 1 only when the counter equals RstHoldCycles.
- rst_sys_n is registered, so it is glitch-free.
- Power-up values: rst_sys_n = 0, counter = 0, sync chain = 0.
- Deassert latency after lock:
  - rst_sys_n rises RstSyncStages + RstHoldCycles + 1 clk_sys edges after locked rises.
  - With defaults this is 19 edges.
- Reset mid-operation: IO_RST high for at least one IO_CLK_BUF edge gives:
  - pll_rst high at the next edge;
  - rst_sys_n low within that IO_CLK cycle;
  - locked drops;
  - full relock plus hold sequence before rst_sys_n rises again.
- IO_RST pulses shorter than one IO_CLK period between edges are ignored, since the input is synchronous.
- Simultaneous loss of lock and reset: same as reset. rst_sys_n is low at most one clk_sys edge after locked falls.
- Steady state: with IO_RST = 0 and locked = 1, rst_sys_n stays 1 indefinitely and never toggles.

Decomposition:
- Shared package sonata_clkgen_pkg holds:
  - constants SysClkHz = 50_000_000 and BoardClkHz = 25_000_000;
  - default ClkMult, RstHoldCycles and RstSyncStages.
- Sub-module sonata_pll, ports clk_in, rst, clk_out, locked.
  - FPGA build: wraps the vendor MMCM/PLL and BUFG.
  - Simulation: behavioural model with lock counter and a clk_out half-period of IO_CLK half-period / ClkMult.
- The reset synchroniser and hold counter stay in sonata_clkgen.

Test Plan:
- Power-up, IO_RST = 0:
  - locked rises 64 IO_CLK cycles after the first IO_CLK_BUF edge;
  - rst_sys_n rises exactly 19 clk_sys edges after lock;
  - then stays 1.
- Frequency check: with a 40 ns IO_CLK period, clk_sys period measures 20 ns ±0.1 ns; IO_CLK_BUF period measures 40 ns with zero phase offset.
- IO_RST held high 10 IO_CLK cycles after steady state:
  - rst_sys_n = 0 at the next IO_CLK_BUF edge;
  - clk_sys stops with no runt pulse;
  - after release: relock (64 cycles) then 19 clk_sys edges before rst_sys_n = 1.
- Model forces locked low for 5 IO_CLK cycles: rst_sys_n falls within 1 clk_sys edge and rises 19 clk_sys edges after relock.
- IO_RST asserted during the hold count (e.g. count = 8): counter returns to 0 and rst_sys_n remains 0 throughout; the full sequence restarts.
- Parameter sweep RstHoldCycles = 1, RstSyncStages = 3: deassert latency is 5 clk_sys edges after lock.
